// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant FSM: state encoding and
// width-derivation helper.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Bit width needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    if (v <= 2) begin
      return 1;
    end else begin
      return $clog2(v);
    end
  endfunction

endpackage

// File: rtl/arb_rr_fsm_rr_pick.sv
// Rotating-priority picker: finds the first requesting agent scanning from
// ptr upward, wrapping modulo NUM_REQ. Purely combinational.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               any,
  output logic [IDW-1:0]     idx
);

  localparam logic [IDW:0] NUM_W = (IDW+1)'(NUM_REQ);

  // Scan offsets from the highest down so the smallest offset from ptr wins.
  always_comb begin
    logic [IDW:0] cand;
    any  = 1'b0;
    idx  = {IDW{1'b0}};
    cand = {(IDW+1){1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= NUM_W) begin
        cand = cand - NUM_W;
      end else begin
        cand = cand;
      end
      if (req[cand[IDW-1:0]]) begin
        any = 1'b1;
        idx = cand[IDW-1:0];
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/arb_rr_fsm.sv
// Round-robin grant FSM with optional bounded hold time. All outputs are
// flops; the priority pointer advances only when an ownership ends.
module arb_rr_fsm
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDW = clog2_min1(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_id,
  output logic               preempt
);

  localparam int HCW = clog2_min1(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  state_t             state;
  state_t             state_nxt;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_nxt;
  logic [HCW-1:0]     hold_cnt;
  logic [HCW-1:0]     hold_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               gnt_valid_nxt;
  logic [IDW-1:0]     gnt_id_nxt;
  logic               preempt_nxt;

  logic               pick_any;
  logic [IDW-1:0]     pick_idx;
  logic               owner_req;
  logic               timeout;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req(req),
    .ptr(ptr),
    .any(pick_any),
    .idx(pick_idx)
  );

  // Owner status: still requesting, and whether its hold budget is used up.
  always_comb begin
    owner_req = req[gnt_id];
    if (MAX_HOLD != 0) begin
      timeout = (hold_cnt == HOLD_LAST);
    end else begin
      timeout = 1'b0;
    end
  end

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    hold_nxt      = hold_cnt;
    gnt_nxt       = gnt;
    gnt_valid_nxt = gnt_valid;
    gnt_id_nxt    = gnt_id;
    preempt_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt     = GRANT;
          gnt_nxt       = NUM_REQ'(1) << pick_idx;
          gnt_valid_nxt = 1'b1;
          gnt_id_nxt    = pick_idx;
          hold_nxt      = {HCW{1'b0}};
        end else begin
          gnt_nxt       = {NUM_REQ{1'b0}};
          gnt_valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (!owner_req || timeout) begin
          // Release: a dropped request wins over a coincident timeout.
          state_nxt     = IDLE;
          gnt_nxt       = {NUM_REQ{1'b0}};
          gnt_valid_nxt = 1'b0;
          hold_nxt      = {HCW{1'b0}};
          preempt_nxt   = timeout && owner_req;
          if (gnt_id == LAST_ID) begin
            ptr_nxt = {IDW{1'b0}};
          end else begin
            ptr_nxt = gnt_id + IDW'(1);
          end
        end else if (MAX_HOLD != 0) begin
          hold_nxt = hold_cnt + HCW'(1);
        end else begin
          hold_nxt = {HCW{1'b0}};
        end
      end
      default: begin
        state_nxt     = IDLE;
        gnt_nxt       = {NUM_REQ{1'b0}};
        gnt_valid_nxt = 1'b0;
        hold_nxt      = {HCW{1'b0}};
      end
    endcase
  end

  // State, pointer, hold counter and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= {IDW{1'b0}};
      hold_cnt  <= {HCW{1'b0}};
      gnt       <= {NUM_REQ{1'b0}};
      gnt_valid <= 1'b0;
      gnt_id    <= {IDW{1'b0}};
      preempt   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= gnt_valid_nxt;
      gnt_id    <= gnt_id_nxt;
      preempt   <= preempt_nxt;
    end
  end

endmodule

// File: tb/tb_arb_rr_fsm.sv
// Bench for arb_rr_fsm: four instances in different configurations, a
// behavioural ownership model checked every cycle, plus hand-computed traces.
module tb_arb_rr_fsm;

  logic clock = 1'b0;
  logic reset;
  logic run = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  logic [3:0] req_a, req_b, req_c, gnt_a, gnt_b, gnt_c;
  logic [6:0] req_w, gnt_w;
  logic       gv_a, gv_b, gv_c, gv_w, pe_a, pe_b, pe_c, pe_w;
  logic [1:0] id_a, id_b, id_c;
  logic [2:0] id_w;

  arb_rr_fsm #(.NUM_REQ(4), .MAX_HOLD(0)) u_a (
    .clock(clock), .reset(reset), .req(req_a), .gnt(gnt_a),
    .gnt_valid(gv_a), .gnt_id(id_a), .preempt(pe_a));
  arb_rr_fsm #(.NUM_REQ(4), .MAX_HOLD(4)) u_b (
    .clock(clock), .reset(reset), .req(req_b), .gnt(gnt_b),
    .gnt_valid(gv_b), .gnt_id(id_b), .preempt(pe_b));
  arb_rr_fsm #(.NUM_REQ(4), .MAX_HOLD(3)) u_c (
    .clock(clock), .reset(reset), .req(req_c), .gnt(gnt_c),
    .gnt_valid(gv_c), .gnt_id(id_c), .preempt(pe_c));
  arb_rr_fsm #(.NUM_REQ(7), .MAX_HOLD(16)) u_w (
    .clock(clock), .reset(reset), .req(req_w), .gnt(gnt_w),
    .gnt_valid(gv_w), .gnt_id(id_w), .preempt(pe_w));

  // Model: who owns the resource, for how many cycles, and where scanning starts.
  typedef struct {
    int owner;
    int len;
    int ptr;
    int id;
    bit pe;
  } mst_t;

  mst_t m [4];

  function automatic mst_t mreset();
    mst_t t;
    t.owner = -1; t.len = 0; t.ptr = 0; t.id = 0; t.pe = 1'b0;
    return t;
  endfunction

  function automatic mst_t mstep(mst_t s, int n, int mh, logic [7:0] r);
    mst_t t;
    int a;
    t = s;
    t.pe = 1'b0;
    if (s.owner < 0) begin
      for (int i = 0; i < n; i++) begin
        a = (s.ptr + i) % n;
        if (r[a] && t.owner < 0) begin
          t.owner = a; t.id = a; t.len = 1;
        end
      end
    end else if (!r[s.owner]) begin
      t.owner = -1; t.ptr = (s.owner + 1) % n;
    end else if (mh != 0 && s.len == mh) begin
      t.owner = -1; t.ptr = (s.owner + 1) % n; t.pe = 1'b1;
    end else begin
      t.len = s.len + 1;
    end
    return t;
  endfunction

  // Advance the model on each rising edge; reset clears it at once.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) m[k] <= mreset();
    end else begin
      m[0] <= mstep(m[0], 4, 0,  {4'b0000, req_a});
      m[1] <= mstep(m[1], 4, 4,  {4'b0000, req_b});
      m[2] <= mstep(m[2], 4, 3,  {4'b0000, req_c});
      m[3] <= mstep(m[3], 7, 16, {1'b0, req_w});
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    logic [7:0] ag [4];
    int aid [4];
    logic agv [4];
    logic ape [4];
    string nm [4];
    int eg;
    nm[0] = "a"; nm[1] = "b"; nm[2] = "c"; nm[3] = "w";
    ag[0] = {4'b0000, gnt_a}; ag[1] = {4'b0000, gnt_b};
    ag[2] = {4'b0000, gnt_c}; ag[3] = {1'b0, gnt_w};
    aid[0] = int'(id_a); aid[1] = int'(id_b); aid[2] = int'(id_c); aid[3] = int'(id_w);
    agv[0] = gv_a; agv[1] = gv_b; agv[2] = gv_c; agv[3] = gv_w;
    ape[0] = pe_a; ape[1] = pe_b; ape[2] = pe_c; ape[3] = pe_w;
    for (int k = 0; k < 4; k++) begin
      eg = (m[k].owner >= 0) ? (1 << m[k].owner) : 0;
      chk({"model.", nm[k], ".gnt"}, int'(ag[k]), eg);
      chk({"model.", nm[k], ".gnt_valid"}, int'(agv[k]), (m[k].owner >= 0) ? 1 : 0);
      chk({"model.", nm[k], ".gnt_id"}, aid[k], m[k].id);
      chk({"model.", nm[k], ".preempt"}, int'(ape[k]), int'(m[k].pe));
    end
  endtask

  // Every falling edge: compare all instances against the model.
  always @(negedge clock) begin
    if (run) cmp_all();
  end

  initial begin
    int tb_g [11];
    int tb_p [11];
    tb_g = '{1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 1};
    tb_p = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

    reset = 1'b1;
    req_a = 4'b0000; req_b = 4'b0000; req_c = 4'b0000; req_w = 7'b0000000;
    @(negedge clock);
    run = 1'b1;
    @(negedge clock);
    chk("rst.gnt", int'(gnt_b), 0);
    chk("rst.gnt_valid", int'(gv_b), 0);
    chk("rst.gnt_id", int'(id_b), 0);
    chk("rst.preempt", int'(pe_b), 0);
    reset = 1'b0;

    // Fairness: three grant cycles, owner drops for one edge, order 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        req_a = (c == 3) ? (4'b1111 & ~(4'b0001 << (k % 4))) : 4'b1111;
        @(negedge clock);
        chk("rr.gnt", int'(gnt_a), (c < 3) ? (1 << (k % 4)) : 0);
      end
    end
    req_a = 4'b0000;

    // Timeout with two persistent requesters, MAX_HOLD=4.
    req_b = 4'b0011;
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      chk("tmo.gnt", int'(gnt_b), tb_g[c]);
      chk("tmo.preempt", int'(pe_b), tb_p[c]);
    end
    req_b = 4'b0000;
    @(negedge clock);
    chk("tmo.drop_gnt", int'(gnt_b), 0);
    chk("tmo.drop_preempt", int'(pe_b), 0);

    // Asynchronous reset mid-grant with owner 2 (pointer was 1 before).
    req_b = 4'b0100;
    @(negedge clock);
    chk("arst.owner", int'(id_b), 2);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst.gnt", int'(gnt_b), 0);
    chk("arst.gnt_valid", int'(gv_b), 0);
    chk("arst.preempt", int'(pe_b), 0);
    req_b = 4'b1111;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("arst.first_id", int'(id_b), 0);
    chk("arst.first_gnt", int'(gnt_b), 1);
    req_b = 4'b0000;
    @(negedge clock);

    // Single persistent requester: 4 grant cycles, 1 idle, repeating.
    req_b = 4'b1000;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clock);
        chk("single.gnt", int'(gnt_b), (c < 4) ? 8 : 0);
        chk("single.gnt_id", int'(id_b), 3);
        chk("single.preempt", int'(pe_b), (c == 4) ? 1 : 0);
      end
    end
    req_b = 4'b0000;
    @(negedge clock);

    // Coincident timeout and request drop, MAX_HOLD=3.
    req_c = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("coin.gnt", int'(gnt_c), 1);
    end
    req_c = 4'b0000;
    @(negedge clock);
    chk("coin.gnt_clear", int'(gnt_c), 0);
    chk("coin.preempt", int'(pe_c), 0);
    req_c = 4'b0011;
    @(negedge clock);
    chk("coin.ptr_next", int'(gnt_c), 2);
    req_c = 4'b0000;
    @(negedge clock);

    // Wide configuration: move pointer to 1, then agents 6 and 0 compete.
    req_w = 7'b0000001;
    @(negedge clock);
    chk("wide.first", int'(id_w), 0);
    req_w = 7'b0000000;
    @(negedge clock);
    req_w = 7'b1000001;
    @(negedge clock);
    chk("wide.gnt6", int'(gnt_w), 64);
    chk("wide.id6", int'(id_w), 6);
    req_w = 7'b0000001;
    @(negedge clock);
    chk("wide.release", int'(gnt_w), 0);
    req_w = 7'b1000001;
    @(negedge clock);
    chk("wide.wrap_gnt", int'(gnt_w), 1);
    chk("wide.wrap_id", int'(id_w), 0);
    req_w = 7'b0000000;
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
